// File: rtl/comparators.sv
// Registered signed equality / less-than comparator with 1-cycle latency.
// Define COMPARATORS_LTU_EN to add the registered unsigned less-than output ltu.
module comparators #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         in_valid,
    output logic         out_valid,
    output logic         equals,
`ifdef COMPARATORS_LTU_EN
    output logic         ltu,
`endif
    output logic         less_than
);

    logic eq_c;
    logic lt_c;
    logic diff_msb;
    logic ovf;
`ifdef COMPARATORS_LTU_EN
    logic carry_out;
`endif

    assign eq_c = &(a ~^ b);

    // Ripple a + ~b + 1; only the sign bit and the final carry are consumed.
    always_comb begin : sub
        logic c;
        c        = 1'b1;
        diff_msb = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i == N - 1) begin
                diff_msb = a[i] ^ ~b[i] ^ c;
            end
            c = (a[i] & ~b[i]) | (c & (a[i] ^ ~b[i]));
        end
`ifdef COMPARATORS_LTU_EN
        carry_out = c;
`endif
    end

    assign ovf  = (a[N-1] ^ b[N-1]) & (diff_msb ^ a[N-1]);
    assign lt_c = diff_msb ^ ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            equals    <= 1'b0;
            less_than <= 1'b0;
`ifdef COMPARATORS_LTU_EN
            ltu       <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                equals    <= eq_c;
                less_than <= lt_c;
`ifdef COMPARATORS_LTU_EN
                ltu       <= ~carry_out;
`endif
            end
        end
    end

endmodule

// File: tb/tb_comparators.sv
// Table-driven bench for comparators: directed vectors, reset/hold sequences, random pairs.
// Optional ltu checks are compiled when COMPARATORS_LTU_EN is defined.
module tb_comparators;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         in_valid;
    logic         out_valid;
    logic         equals;
    logic         less_than;
`ifdef COMPARATORS_LTU_EN
    logic         ltu;
`endif

    int vectors = 0;
    int miscompares = 0;

    comparators #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .out_valid (out_valid),
        .equals    (equals),
`ifdef COMPARATORS_LTU_EN
        .ltu       (ltu),
`endif
        .less_than (less_than)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         rst;
        logic         iv;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         ov;
        logic         eq;
        logic         lt;
        logic         lu;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample outputs just after the edge.
    task automatic apply(input vec_t v);
        rst      = v.rst;
        in_valid = v.iv;
        a        = v.a;
        b        = v.b;
        @(posedge clk);
        #1;
        check({v.name, ".out_valid"}, out_valid, v.ov);
        check({v.name, ".equals"}, equals, v.eq);
        check({v.name, ".less_than"}, less_than, v.lt);
`ifdef COMPARATORS_LTU_EN
        check({v.name, ".ltu"}, ltu, v.lu);
`endif
    endtask

    function automatic vec_t mk(input string n, input logic r, input logic iv,
                                input logic [N-1:0] av, input logic [N-1:0] bv,
                                input logic ov, input logic eq, input logic lt,
                                input logic lu);
        vec_t v;
        v.name = n; v.rst = r; v.iv = iv; v.a = av; v.b = bv;
        v.ov = ov; v.eq = eq; v.lt = lt; v.lu = lu;
        return v;
    endfunction

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;

        //            name          rst   iv  a             b             ov eq lt lu
        tbl.push_back(mk("reset0",   1'b1, 1'b1, 32'd5,        32'd5,        0, 0, 0, 0));
        tbl.push_back(mk("reset1",   1'b1, 1'b1, 32'd5,        32'd5,        0, 0, 0, 0));
        tbl.push_back(mk("zero",     1'b0, 1'b1, 32'd0,        32'd0,        1, 1, 0, 0));
        tbl.push_back(mk("m1_1",     1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        1, 0, 1, 0));
        tbl.push_back(mk("eq38273",  1'b0, 1'b1, 32'd38273,    32'd38273,    1, 1, 0, 0));
        tbl.push_back(mk("m3_7",     1'b0, 1'b1, -32'sd3,      32'd7,        1, 0, 1, 0));
        tbl.push_back(mk("7_m3",     1'b0, 1'b1, 32'd7,        -32'sd3,      1, 0, 0, 1));
        tbl.push_back(mk("m5_m2",    1'b0, 1'b1, -32'sd5,      -32'sd2,      1, 0, 1, 1));
        tbl.push_back(mk("m2_m5",    1'b0, 1'b1, -32'sd2,      -32'sd5,      1, 0, 0, 0));
        tbl.push_back(mk("ovf9_7",   1'b0, 1'b1, 32'h90000000, 32'h70000000, 1, 0, 1, 0));
        tbl.push_back(mk("ovf7_9",   1'b0, 1'b1, 32'h70000000, 32'h90000000, 1, 0, 0, 1));
        tbl.push_back(mk("minneg",   1'b0, 1'b1, 32'h80000000, 32'h80000000, 1, 1, 0, 0));
        tbl.push_back(mk("min_max",  1'b0, 1'b1, 32'h80000000, 32'h7FFFFFFF, 1, 0, 1, 0));
        tbl.push_back(mk("max_min",  1'b0, 1'b1, 32'h7FFFFFFF, 32'h80000000, 1, 0, 0, 1));
        tbl.push_back(mk("eq7999",   1'b0, 1'b1, 32'h79999999, 32'h79999999, 1, 1, 0, 0));
        tbl.push_back(mk("ltu_chk",  1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        1, 0, 1, 0));
        tbl.push_back(mk("m5_m2b",   1'b0, 1'b1, -32'sd5,      -32'sd2,      1, 0, 1, 1));
        tbl.push_back(mk("hold0",    1'b0, 1'b0, 32'd9,        32'd9,        0, 0, 1, 1));
        tbl.push_back(mk("hold1",    1'b0, 1'b0, 32'd1,        32'd2,        0, 0, 1, 1));
        tbl.push_back(mk("resume",   1'b0, 1'b1, 32'd4,        32'd4,        1, 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Mid-stream reset discards the in-flight pair; idle cycle follows before the next result.
        apply(mk("mid_pre",   1'b0, 1'b1, -32'sd3, 32'd7, 1, 0, 1, 0));
        apply(mk("mid_rst",   1'b1, 1'b1, 32'd3,   32'd3, 0, 0, 0, 0));
        apply(mk("mid_idle",  1'b0, 1'b0, 32'd3,   32'd3, 0, 0, 0, 0));
        apply(mk("mid_first", 1'b0, 1'b1, 32'd3,   32'd3, 1, 1, 0, 0));

        // Back-to-back random pairs, each checked one edge after it is sampled.
        for (int i = 0; i < 1000; i++) begin
            ra = $random;
            rb = (i % 8 == 0) ? ra : $random;
            rst = 1'b0; in_valid = 1'b1; a = ra; b = rb;
            @(posedge clk);
            #1;
            check("rnd.out_valid", out_valid, 1'b1);
            check("rnd.equals", equals, ra == rb);
            check("rnd.less_than", less_than, $signed(ra) < $signed(rb));
`ifdef COMPARATORS_LTU_EN
            check("rnd.ltu", ltu, ra < rb);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
